branch_predictor: RTL and testbench

Dynamic branch-direction predictor for the processor's fetch path. It predicts the taken/not-taken outcome of conditional branches (`beq`/`bne`/`blt`) before the branch comparator resolves them. It is trained afterwards by the comparator's resolved `selection_line`. It holds a table of 2-bit saturating counters indexed by PC and keeps branch and misprediction statistics.

---
 rtl/branch_predictor_if.sv | 26 ++
 rtl/branch_predictor.sv | 106 ++++++++++
 tb/tb_branch_predictor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and resolve-side training signals of the branch predictor.
// The predictor connects through the slave modport, the fetch/resolve logic through master.
interface branch_predictor_if #(
    parameter int unsigned CNT_W = 32
);
    logic [63:0]      pred_pc;
    logic             pred_taken;
    logic             upd_valid;
    logic             upd_branch;
    logic [63:0]      upd_pc;
    logic             upd_taken;
    logic             upd_pred;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output pred_pc, upd_valid, upd_branch, upd_pc, upd_taken, upd_pred,
        input  pred_taken, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  pred_pc, upd_valid, upd_branch, upd_pc, upd_taken, upd_pred,
        output pred_taken, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Table of 2-bit saturating direction counters indexed by PC, plus branch/mispredict stats.
// Optional gshare indexing (global history XOR PC) is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input logic              clk,
    input logic              reset,
    branch_predictor_if.slave bp
);
    localparam int unsigned Entries = 2 ** INDEX_W;

    logic [1:0]         cnt_table_q [Entries];
    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic               accept;
    logic [1:0]         upd_cnt;
    logic [1:0]         upd_cnt_d;
    logic [CNT_W-1:0]   branch_count_q;
    logic [CNT_W-1:0]   branch_count_d;
    logic [CNT_W-1:0]   mispredict_count_q;
    logic [CNT_W-1:0]   mispredict_count_d;
    logic               mispredict_q;
    logic               mispredict_d;

    // Only the index bits of the PCs take part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pred_pc[63:INDEX_W+2], bp.pred_pc[1:0],
                              bp.upd_pc[63:INDEX_W+2], bp.upd_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [INDEX_W-1:0] ghr_q;
    logic [INDEX_W-1:0] ghr_d;

    // Both lookup and update hash with the history as it stood before this edge.
    assign pred_idx = bp.pred_pc[INDEX_W+1:2] ^ ghr_q;
    assign upd_idx  = bp.upd_pc[INDEX_W+1:2] ^ ghr_q;

    always_comb begin
        ghr_d = ghr_q;
        if (accept) begin
            ghr_d = {ghr_q[INDEX_W-2:0], bp.upd_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign pred_idx = bp.pred_pc[INDEX_W+1:2];
    assign upd_idx  = bp.upd_pc[INDEX_W+1:2];
`endif

    assign accept = bp.upd_valid & bp.upd_branch;
    assign upd_cnt = cnt_table_q[upd_idx];

    always_comb begin
        upd_cnt_d          = upd_cnt;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        mispredict_d       = 1'b0;
        if (accept) begin
            if (bp.upd_taken) begin
                if (upd_cnt != 2'b11) begin
                    upd_cnt_d = upd_cnt + 2'd1;
                end
            end else if (upd_cnt != 2'b00) begin
                upd_cnt_d = upd_cnt - 2'd1;
            end
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
            mispredict_d = bp.upd_pred != bp.upd_taken;
            if (mispredict_d && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                cnt_table_q[i] <= 2'b01;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            mispredict_q       <= 1'b0;
        end else begin
            if (accept) begin
                cnt_table_q[upd_idx] <= upd_cnt_d;
            end
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            mispredict_q       <= mispredict_d;
        end
    end

    assign bp.pred_taken       = cnt_table_q[pred_idx][1];
    assign bp.mispredict       = mispredict_q;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, corner sequences,
// and randomized traffic against a counter-array reference model.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.CNT_W(32)) bp ();
    branch_predictor_if #(.CNT_W(3))  bp_s ();

    // Narrow-counter copy sees identical traffic so stat saturation is reachable.
    assign bp_s.pred_pc    = bp.pred_pc;
    assign bp_s.upd_valid  = bp.upd_valid;
    assign bp_s.upd_branch = bp.upd_branch;
    assign bp_s.upd_pc     = bp.upd_pc;
    assign bp_s.upd_taken  = bp.upd_taken;
    assign bp_s.upd_pred   = bp.upd_pred;

    branch_predictor #(.INDEX_W(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    branch_predictor #(.INDEX_W(4), .CNT_W(3)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_s)
    );

    // Reference model: plain integer counters per table slot.
    int     m_cnt [16];
    int     m_ghr;
    longint m_bc, m_mc;
    int     m_bcs, m_mcs;
    bit     m_mis;

    function automatic int midx(input logic [63:0] pc);
        return int'((pc >> 2) & 64'hF) ^ m_ghr;
    endfunction

    function automatic bit mpred(input logic [63:0] pc);
        return m_cnt[midx(pc)] >= 2;
    endfunction

    task automatic model_step(input bit valid, input bit branch, input logic [63:0] pc,
                              input bit taken, input bit pred, input bit rst);
        int i;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_cnt[k] = 1;
            m_ghr = 0; m_bc = 0; m_mc = 0; m_bcs = 0; m_mcs = 0; m_mis = 0;
            return;
        end
        m_mis = valid && branch && (pred != taken);
        if (valid && branch) begin
            i = midx(pc);
            m_cnt[i] = taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                             : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (m_bcs < 7) m_bcs++;
            if (m_mis) begin
                if (m_mc < 64'hFFFF_FFFF) m_mc++;
                if (m_mcs < 7) m_mcs++;
            end
`ifdef BP_GSHARE_EN
            m_ghr = ((m_ghr << 1) | int'(taken)) & 15;
`endif
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit valid, input bit branch, input logic [63:0] pc,
                         input bit taken, input bit pred);
        bp.upd_valid  = valid;
        bp.upd_branch = branch;
        bp.upd_pc     = pc;
        bp.upd_taken  = taken;
        bp.upd_pred   = pred;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit          valid;
        bit          branch;
        logic [63:0] pc;
        bit          taken;
        bit          pred;
        bit          exp_pt;
        bit          exp_mis;
        int          exp_bc;
        int          exp_mc;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs = '{
            '{1, 1, 64'h40, 1, 0, 1, 1, 1, 1},
            '{1, 1, 64'h40, 1, 0, 1, 1, 2, 2},
            '{1, 1, 64'h40, 1, 0, 1, 1, 3, 3},
            '{1, 1, 64'h40, 0, 1, 1, 1, 4, 4},
            '{1, 1, 64'h40, 0, 1, 0, 1, 5, 5},
            '{1, 1, 64'h10, 1, 0, 1, 1, 6, 6},
            '{1, 1, 64'h10, 1, 1, 1, 0, 7, 6},
            '{1, 1, 64'h10, 1, 1, 1, 0, 8, 6},
            '{1, 1, 64'h10, 1, 1, 1, 0, 9, 6},
            '{1, 1, 64'h10, 1, 1, 1, 0, 10, 6},
            '{1, 1, 64'h10, 0, 1, 1, 1, 11, 7},
            '{1, 0, 64'h40, 1, 0, 0, 0, 11, 7},
            '{1, 0, 64'h40, 1, 0, 0, 0, 11, 7},
            '{1, 0, 64'h40, 1, 0, 0, 0, 11, 7},
            '{1, 0, 64'h40, 1, 0, 0, 0, 11, 7},
            '{0, 1, 64'h40, 1, 0, 0, 0, 11, 7}
        };

        idle();
        bp.pred_pc = 64'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int a = 0; a <= 'h3C; a += 4) begin
            bp.pred_pc = 64'(a);
            #1;
            check($sformatf("reset_pred_%0h", a), 64'(bp.pred_taken), 64'h0);
        end
        check("reset_branch_count", 64'(bp.branch_count), 64'h0);
        check("reset_mispredict_count", 64'(bp.mispredict_count), 64'h0);
        check("reset_mispredict", 64'(bp.mispredict), 64'h0);

        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].valid, vecs[v].branch, vecs[v].pc, vecs[v].taken, vecs[v].pred);
            bp.pred_pc = vecs[v].pc;
            tick();
            idle();
            #1;
            check($sformatf("vec%0d_pred", v), 64'(bp.pred_taken), 64'(vecs[v].exp_pt));
            check($sformatf("vec%0d_mis", v), 64'(bp.mispredict), 64'(vecs[v].exp_mis));
            check($sformatf("vec%0d_bc", v), 64'(bp.branch_count), 64'(vecs[v].exp_bc));
            check($sformatf("vec%0d_mc", v), 64'(bp.mispredict_count), 64'(vecs[v].exp_mc));
        end

        bp.pred_pc = 64'h50;
        #1;
        check("alias_0x50", 64'(bp.pred_taken), 64'h1);

        // Same-cycle read and update of entry 0x24 (still weak not-taken).
        bp.pred_pc = 64'h24;
        drive(1'b1, 1'b1, 64'h24, 1'b1, 1'b0);
        #1;
        check("same_cycle_pre", 64'(bp.pred_taken), 64'h0);
        tick();
        idle();
        #1;
        check("same_cycle_post", 64'(bp.pred_taken), 64'h1);

        // Train 0x08 to strong-taken, then reset alongside another taken update.
        bp.pred_pc = 64'h08;
        drive(1'b1, 1'b1, 64'h08, 1'b1, 1'b0);
        tick();
        tick();
        check("train_0x08", 64'(bp.pred_taken), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("midreset_pred", 64'(bp.pred_taken), 64'h0);
        check("midreset_bc", 64'(bp.branch_count), 64'h0);
        check("midreset_mc", 64'(bp.mispredict_count), 64'h0);
        check("midreset_mis", 64'(bp.mispredict), 64'h0);

        model_step(0, 0, 64'h0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            bit          valid, branch, taken, pred, rst;
            logic [63:0] pc;
            valid  = $urandom_range(0, 3) != 0;
            branch = $urandom_range(0, 3) != 0;
            taken  = 1'($urandom);
            pred   = 1'($urandom);
            rst    = $urandom_range(0, 299) == 0;
            pc     = {$urandom, $urandom};
            drive(valid, branch, pc, taken, pred);
            bp.pred_pc = ($urandom_range(0, 3) == 0) ? pc : {$urandom, $urandom};
            reset = rst;
            #1;
            check("rand_pred", 64'(bp.pred_taken), 64'(mpred(bp.pred_pc)));
            check("rand_pred_s", 64'(bp_s.pred_taken), 64'(mpred(bp.pred_pc)));
            tick();
            model_step(valid, branch, pc, taken, pred, rst);
            check("rand_mis", 64'(bp.mispredict), 64'(m_mis));
            check("rand_bc", 64'(bp.branch_count), 64'(m_bc));
            check("rand_mc", 64'(bp.mispredict_count), 64'(m_mc));
            check("rand_bc_sat", 64'(bp_s.branch_count), 64'(m_bcs));
            check("rand_mc_sat", 64'(bp_s.mispredict_count), 64'(m_mcs));
        end
        reset = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
